// File: rtl/sokoban_pkg.sv
// -----------------------------------------------------------------------------
// sokoban_pkg
//   Shared definitions for the Sokoban map controller: board geometry, move
//   direction codes, move result codes, FSM state encodings and the win rule.
//   No ports (package).
// -----------------------------------------------------------------------------
package sokoban_pkg;

   localparam int GRID  = 8;
   localparam int CELLS = GRID * GRID;
   localparam int IDX_W = 6;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      RES_WALK  = 2'd0,
      RES_PUSH  = 2'd1,
      RES_BLOCK = 2'd2
   } res_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EVAL   = 2'd1,
      S_UPDATE = 2'd2,
      S_WIN    = 2'd3
   } state_e;

   // A board is won when at least one box exists and every box sits on a
   // destination cell.
   function automatic logic board_won(input logic [CELLS-1:0] box,
                                      input logic [CELLS-1:0] dst);
      return ((box & ~dst) == '0) && (box != '0);
   endfunction

endpackage

// File: rtl/sokoban_step_calc.sv
// -----------------------------------------------------------------------------
// sokoban_step_calc
//   Combinational neighbour lookup. For a cell index and a direction it gives
//   the target cell one step away and the cell two steps away, plus flags that
//   say whether either of them falls off the 8x8 grid. Row wrap-around is
//   treated as off-grid, never as a neighbouring cell.
// Ports:
//   idx   in  6  current cell {row, col}
//   dir   in  2  move direction code (DIR_*)
//   t     out 6  target cell (meaningless when t_off)
//   b     out 6  beyond cell (meaningless when b_off)
//   t_off out 1  target is off-grid
//   b_off out 1  beyond is off-grid
// -----------------------------------------------------------------------------
module sokoban_step_calc
   import sokoban_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  logic [1:0]       dir,
   output logic [IDX_W-1:0] t,
   output logic [IDX_W-1:0] b,
   output logic             t_off,
   output logic             b_off
);

   localparam logic [IDX_W-1:0] ROW_STEP = IDX_W'(GRID);
   localparam logic [2:0]       LAST     = 3'(GRID - 1);

   logic [2:0] row;
   logic [2:0] col;

   assign row = idx[5:3];
   assign col = idx[2:0];

   // Index arithmetic wraps modulo 64 when a step leaves the board; the
   // off-grid flags are what make such results irrelevant.
   always_comb begin
      t     = idx;
      b     = idx;
      t_off = 1'b0;
      b_off = 1'b0;
      case (dir)
         DIR_UP: begin
            t     = idx - ROW_STEP;
            b     = idx - (ROW_STEP << 1);
            t_off = (row == 3'd0);
            b_off = (row <= 3'd1);
         end
         DIR_DOWN: begin
            t     = idx + ROW_STEP;
            b     = idx + (ROW_STEP << 1);
            t_off = (row == LAST);
            b_off = (row >= LAST - 3'd1);
         end
         DIR_LEFT: begin
            t     = idx - 6'd1;
            b     = idx - 6'd2;
            t_off = (col == 3'd0);
            b_off = (col <= 3'd1);
         end
         DIR_RIGHT: begin
            t     = idx + 6'd1;
            b     = idx + 6'd2;
            t_off = (col == LAST);
            b_off = (col >= LAST - 3'd1);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sokoban_map_ctrl.sv
// -----------------------------------------------------------------------------
// sokoban_map_ctrl
//   Owner of the 8x8 Sokoban game state. Loads levels, resolves single-step
//   moves (walk / push one box / blocked), counts successful steps and flags
//   the win condition. Writer side of the map interface read by render layers.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   load_valid/load_ready           level load handshake
//   load_man, load_box/way/wall/dst initial level contents
//   move_valid/move_ready, move_dir move request handshake (0 up,1 dn,2 l,3 r)
//   move_done, move_result          one-cycle resolution pulse and result code
//   man, box, way, wall, destination board state
//   steps                           successful moves since load (saturating)
//   win                             all boxes on destinations
// -----------------------------------------------------------------------------
module sokoban_map_ctrl
   import sokoban_pkg::*;
#(
   parameter int STEP_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [IDX_W-1:0]   load_man,
   input  logic [CELLS-1:0]   load_box,
   input  logic [CELLS-1:0]   load_way,
   input  logic [CELLS-1:0]   load_wall,
   input  logic [CELLS-1:0]   load_dst,
   input  logic               move_valid,
   input  logic [1:0]         move_dir,
   output logic               move_ready,
   output logic               move_done,
   output logic [1:0]         move_result,
   output logic [IDX_W-1:0]   man,
   output logic [CELLS-1:0]   box,
   output logic [CELLS-1:0]   way,
   output logic [CELLS-1:0]   wall,
   output logic [CELLS-1:0]   destination,
   output logic [STEP_W-1:0]  steps,
   output logic               win
);

   function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
      return (&v) ? v : v + STEP_W'(1);
   endfunction

   state_e             state_q;
   state_e             state_d;

   // chk_pend marks the cycle right after a load or a move update, during
   // which win is re-evaluated from the freshly written box map. Moves are
   // held off for that cycle so a win can never race a new move.
   logic               chk_pend;

   logic [1:0]         dir_p0;
   res_e               res_p1;
   logic [IDX_W-1:0]   t_p1;
   logic [IDX_W-1:0]   b_p1;

   logic [IDX_W-1:0]   t_cell;
   logic [IDX_W-1:0]   b_cell;
   logic               t_off;
   logic               b_off;
   res_e               res_d;
   logic               load_fire;
   logic               move_fire;
   logic               won_now;

   assign load_ready = (state_q == S_IDLE) || (state_q == S_WIN);
   assign move_ready = (state_q == S_IDLE) && !load_valid && !chk_pend;
   assign load_fire  = load_valid && load_ready;
   assign move_fire  = move_valid && move_ready;
   assign won_now    = board_won(box, destination);

   sokoban_step_calc u_step_calc (
      .idx   (man),
      .dir   (dir_p0),
      .t     (t_cell),
      .b     (b_cell),
      .t_off (t_off),
      .b_off (b_off)
   );

   always_comb begin
      res_d = RES_WALK;
      if (t_off || wall[t_cell]) begin
         res_d = RES_BLOCK;
      end else if (box[t_cell] && (b_off || wall[b_cell] || box[b_cell])) begin
         res_d = RES_BLOCK;
      end else if (box[t_cell]) begin
         res_d = RES_PUSH;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (load_valid) begin
               state_d = S_IDLE;
            end else if (chk_pend && won_now) begin
               state_d = S_WIN;
            end else if (move_fire) begin
               state_d = S_EVAL;
            end
         end
         S_EVAL:   state_d = S_UPDATE;
         S_UPDATE: state_d = S_IDLE;
         S_WIN: begin
            if (load_valid) begin
               state_d = S_IDLE;
            end
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_pend    <= 1'b0;
         dir_p0      <= 2'd0;
         res_p1      <= RES_WALK;
         t_p1        <= '0;
         b_p1        <= '0;
         man         <= '0;
         box         <= '0;
         way         <= '0;
         wall        <= '0;
         destination <= '0;
         steps       <= '0;
         win         <= 1'b0;
         move_done   <= 1'b0;
         move_result <= RES_WALK;
      end else begin
         move_done <= 1'b0;
         if (load_fire) begin
            man         <= load_man;
            box         <= load_box;
            way         <= load_way;
            wall        <= load_wall;
            destination <= load_dst;
            steps       <= '0;
            move_result <= RES_WALK;
            win         <= 1'b0;
            chk_pend    <= 1'b1;
         end else begin
            chk_pend <= 1'b0;
            if (chk_pend) begin
               win <= won_now;
            end

            // p0: direction captured at the move handshake
            if (move_fire) begin
               dir_p0 <= move_dir;
            end

            case (state_q)
               // p1: decision and cell indices registered in S_EVAL
               S_EVAL: begin
                  res_p1 <= res_d;
                  t_p1   <= t_cell;
                  b_p1   <= b_cell;
               end
               // p2: board update and result report in S_UPDATE
               S_UPDATE: begin
                  move_done   <= 1'b1;
                  move_result <= res_p1;
                  chk_pend    <= 1'b1;
                  if (res_p1 != RES_BLOCK) begin
                     man   <= t_p1;
                     steps <= sat_inc(steps);
                  end
                  if (res_p1 == RES_PUSH) begin
                     box[t_p1] <= 1'b0;
                     box[b_p1] <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sokoban_map_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sokoban_map_ctrl
//   Directed and randomized bench for sokoban_map_ctrl against a cell-level
//   game model (row/column arithmetic on plain bit arrays).
// -----------------------------------------------------------------------------
module tb_sokoban_map_ctrl;

   localparam int STEP_W = 10;
   localparam int MAXS   = (1 << STEP_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_valid = 1'b0;
   logic              load_ready;
   logic [5:0]        load_man = '0;
   logic [63:0]       load_box = '0;
   logic [63:0]       load_way = '0;
   logic [63:0]       load_wall = '0;
   logic [63:0]       load_dst = '0;
   logic              move_valid = 1'b0;
   logic [1:0]        move_dir = '0;
   logic              move_ready;
   logic              move_done;
   logic [1:0]        move_result;
   logic [5:0]        man;
   logic [63:0]       box;
   logic [63:0]       way;
   logic [63:0]       wall;
   logic [63:0]       destination;
   logic [STEP_W-1:0] steps;
   logic              win;

   sokoban_map_ctrl #(.STEP_W(STEP_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_man    (load_man),
      .load_box    (load_box),
      .load_way    (load_way),
      .load_wall   (load_wall),
      .load_dst    (load_dst),
      .move_valid  (move_valid),
      .move_dir    (move_dir),
      .move_ready  (move_ready),
      .move_done   (move_done),
      .move_result (move_result),
      .man         (man),
      .box         (box),
      .way         (way),
      .wall        (wall),
      .destination (destination),
      .steps       (steps),
      .win         (win)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;

   int          m_man;
   int          m_steps;
   int          m_res;
   logic        m_win;
   logic [63:0] m_box;
   logic [63:0] m_way;
   logic [63:0] m_wall;
   logic [63:0] m_dst;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_won();
      int nbox;
      logic ok;
      nbox = 0;
      ok   = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (m_box[i]) begin
            nbox++;
            if (!m_dst[i]) ok = 1'b0;
         end
      end
      return ok && (nbox > 0);
   endfunction

   function automatic int model_move(input int d);
      int r, c, dr, dc, tr, tc, br, bc, t, b;
      r  = m_man / 8;
      c  = m_man % 8;
      dr = 0;
      dc = 0;
      case (d)
         0: dr = -1;
         1: dr = 1;
         2: dc = -1;
         default: dc = 1;
      endcase
      tr = r + dr;
      tc = c + dc;
      if (tr < 0 || tr > 7 || tc < 0 || tc > 7) return 2;
      t = tr * 8 + tc;
      if (m_wall[t]) return 2;
      if (m_box[t]) begin
         br = tr + dr;
         bc = tc + dc;
         if (br < 0 || br > 7 || bc < 0 || bc > 7) return 2;
         b = br * 8 + bc;
         if (m_wall[b] || m_box[b]) return 2;
         m_box[t] = 1'b0;
         m_box[b] = 1'b1;
         m_man = t;
         if (m_steps < MAXS) m_steps++;
         return 1;
      end
      m_man = t;
      if (m_steps < MAXS) m_steps++;
      return 0;
   endfunction

   task automatic check_board(input string tag);
      chk({tag, "_man"},   64'(man),   64'(m_man));
      chk({tag, "_box"},   box,        m_box);
      chk({tag, "_steps"}, 64'(steps), 64'(m_steps));
   endtask

   task automatic do_load(input int mn, input logic [63:0] bx, input logic [63:0] wy,
                          input logic [63:0] wl, input logic [63:0] ds);
      chk("load_ready", 64'(load_ready), 64'd1);
      load_man   = 6'(mn);
      load_box   = bx;
      load_way   = wy;
      load_wall  = wl;
      load_dst   = ds;
      load_valid = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
      m_man = mn; m_box = bx; m_way = wy; m_wall = wl; m_dst = ds;
      m_steps = 0; m_res = 0;
      check_board("load");
      chk("load_wall",   wall,              m_wall);
      chk("load_way",    way,               m_way);
      chk("load_dst",    destination,       m_dst);
      chk("load_result", 64'(move_result),  64'd0);
      @(posedge clk); #1;
      m_win = model_won();
      chk("load_win",        64'(win),        64'(m_win));
      chk("load_move_ready", 64'(move_ready), 64'(!m_win));
   endtask

   task automatic do_move(input int d);
      int waited;
      waited = 0;
      while (!move_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("move_ready_wait", 64'(move_ready), 64'd1);
      move_dir   = 2'(d);
      move_valid = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      m_res = model_move(d);
      @(posedge clk); #1;
      chk("done_early", 64'(move_done), 64'd0);
      @(posedge clk); #1;
      chk("done_pulse", 64'(move_done),   64'd1);
      chk("result",     64'(move_result), 64'(m_res));
      check_board("move");
      @(posedge clk); #1;
      m_win = model_won();
      chk("done_clear",      64'(move_done),  64'd0);
      chk("move_win",        64'(win),        64'(m_win));
      chk("move_ready_post", 64'(move_ready), 64'(!m_win));
   endtask

   logic [63:0] border;
   logic [63:0] rb, rw, rd;
   int          rm;

   initial begin
      // Reset state
      #1;
      chk("rst_man",    64'(man),         64'd0);
      chk("rst_box",    box,              64'd0);
      chk("rst_wall",   wall,             64'd0);
      chk("rst_steps",  64'(steps),       64'd0);
      chk("rst_win",    64'(win),         64'd0);
      chk("rst_done",   64'(move_done),   64'd0);
      chk("rst_result", 64'(move_result), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      border = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if (r == 0 || r == 7 || c == 0 || c == 7) border[r*8+c] = 1'b1;

      // Push onto destination and win
      do_load(9, 64'(1) << 10, ~border, border, 64'(1) << 11);
      do_move(3);
      chk("t1_man",    64'(man),         64'd10);
      chk("t1_result", 64'(move_result), 64'd1);
      chk("t1_win",    64'(win),         64'd1);
      move_valid = 1'b1;
      move_dir   = 2'd1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("t1_win_ready", 64'(move_ready), 64'd0);
         chk("t1_win_done",  64'(move_done),  64'd0);
      end
      move_valid = 1'b0;
      chk("t1_win_man", 64'(man), 64'd10);

      // Box against a wall
      do_load(9, 64'(1) << 10, ~border, border | (64'(1) << 11), 64'(1) << 12);
      do_move(3);
      chk("t2_result", 64'(move_result), 64'd2);
      chk("t2_man",    64'(man),         64'd9);

      // Grid edges, no row wrap
      do_load(7, '0, '1, '0, '0);
      do_move(3);
      chk("t3_right_edge", 64'(man), 64'd7);
      do_move(0);
      chk("t3_top_edge",   64'(man), 64'd7);
      do_load(8, '0, '1, '0, '0);
      do_move(2);
      chk("t3_left_edge",  64'(man), 64'd8);

      // Double box, then walk down
      do_load(9, (64'(1) << 10) | (64'(1) << 11), '1, '0, 64'(1) << 50);
      do_move(3);
      chk("t4_double", 64'(move_result), 64'd2);
      do_move(1);
      chk("t4_walk_man",   64'(man),   64'd17);
      chk("t4_walk_steps", 64'(steps), 64'd1);

      // Reset during S_EVAL
      do_load(27, 64'(1) << 28, '1, '0, '0);
      move_dir   = 2'd3;
      move_valid = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t5_man",    64'(man),         64'd0);
      chk("t5_box",    box,              64'd0);
      chk("t5_steps",  64'(steps),       64'd0);
      chk("t5_done",   64'(move_done),   64'd0);
      chk("t5_result", 64'(move_result), 64'd0);
      chk("t5_idle",   64'(load_ready),  64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("t5_no_done", 64'(move_done), 64'd0);
         chk("t5_no_move", 64'(man),       64'd0);
      end

      // Step counter saturation
      do_load(27, '0, '1, '0, '0);
      for (int i = 0; i <= MAXS; i++) do_move((i % 2 == 0) ? 3 : 2);
      chk("t6_sat", 64'(steps), 64'(MAXS));

      // move_valid during S_UPDATE is ignored
      do_load(27, '0, '1, '0, '0);
      move_dir   = 2'd3;
      move_valid = 1'b1;
      @(posedge clk); #1;
      m_res = model_move(3);
      move_valid = 1'b0;
      @(posedge clk); #1;
      move_dir   = 2'd2;
      move_valid = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      chk("t7_done", 64'(move_done), 64'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("t7_no_done", 64'(move_done), 64'd0);
      end
      check_board("t7");

      // Load and move together: load only
      load_man   = 6'd20;
      load_box   = '0;
      load_way   = '1;
      load_wall  = '0;
      load_dst   = '0;
      load_valid = 1'b1;
      move_dir   = 2'd1;
      move_valid = 1'b1;
      #1;
      chk("t8_move_ready", 64'(move_ready), 64'd0);
      @(posedge clk); #1;
      load_valid = 1'b0;
      move_valid = 1'b0;
      m_man = 20; m_box = '0; m_wall = '0; m_dst = '0; m_steps = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("t8_no_done", 64'(move_done), 64'd0);
      end
      check_board("t8");

      // Randomized levels and moves
      for (int lv = 0; lv < 8; lv++) begin
         rb = '0; rw = '0; rd = '0;
         for (int i = 0; i < 64; i++) begin
            rw[i] = ($urandom_range(0, 4) == 0);
            rb[i] = !rw[i] && ($urandom_range(0, 5) == 0);
            rd[i] = ($urandom_range(0, 5) == 0);
         end
         if (lv % 2 == 1) rd = rd | (rb & ~(rb - 64'd1)) ^ rb;
         rm = $urandom_range(0, 63);
         rw[rm] = 1'b0;
         rb[rm] = 1'b0;
         do_load(rm, rb, ~rw, rw, rd);
         for (int mv = 0; mv < 40; mv++) begin
            if (m_win) break;
            do_move($urandom_range(0, 3));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
